// File: rtl/display_frame_decoder.sv
// Rebuilds a segment vector from NB_FRAMES randomised frames by counting ON hits per segment and thresholding.
// Optional DISPLAY_DECODER_CONFIDENCE_EN adds msg_unsure, which flags counts between THRESH_LO and THRESH.
module display_frame_decoder #(
  parameter int unsigned NB_SEGMENTS = 56,
  parameter int unsigned BEAT_W      = 8,
  parameter int unsigned NB_FRAMES   = 16,
  parameter int unsigned THRESH      = 8,
  parameter int unsigned CNT_W       = 5
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
  , parameter int unsigned THRESH_LO = 3
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BEAT_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   msg_valid,
  input  logic                   msg_ready,
  output logic [NB_SEGMENTS-1:0] msg,
  output logic                   frame_err
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
  , output logic [NB_SEGMENTS-1:0] msg_unsure
`endif
);

  localparam int unsigned NB_BEATS = NB_SEGMENTS / BEAT_W;
  localparam int unsigned BI_W     = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
  localparam int unsigned FI_W     = $clog2(NB_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] THR        = CNT_W'(THRESH);
  localparam logic [BI_W-1:0]  LAST_BEAT  = BI_W'(NB_BEATS - 1);
  localparam logic [FI_W-1:0]  LAST_FRAME = FI_W'(NB_FRAMES - 1);
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
  localparam logic [CNT_W-1:0] THR_LO     = CNT_W'(THRESH_LO);
`endif

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q [NB_SEGMENTS];
  logic [CNT_W-1:0]       cnt_d [NB_SEGMENTS];
  logic [CNT_W-1:0]       cnt_inc [NB_SEGMENTS];
  logic [BI_W-1:0]        beat_q, beat_d;
  logic [FI_W-1:0]        frame_q, frame_d;
  logic                   in_ready_d, msg_valid_d, frame_err_d;
  logic [NB_SEGMENTS-1:0] msg_d;
  logic                   beat_acc, last_beat;
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
  logic [NB_SEGMENTS-1:0] unsure_d;
`endif

  // Register stage: FSM state, counters and all outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      beat_q    <= '0;
      frame_q   <= '0;
      in_ready  <= 1'b0;
      msg_valid <= 1'b0;
      msg       <= '0;
      frame_err <= 1'b0;
      for (int j = 0; j < int'(NB_SEGMENTS); j++) cnt_q[j] <= '0;
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
      msg_unsure <= '0;
`endif
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      frame_q   <= frame_d;
      in_ready  <= in_ready_d;
      msg_valid <= msg_valid_d;
      msg       <= msg_d;
      frame_err <= frame_err_d;
      for (int j = 0; j < int'(NB_SEGMENTS); j++) cnt_q[j] <= cnt_d[j];
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
      msg_unsure <= unsure_d;
`endif
    end
  end

  // Next-state, counter update and output decode
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    frame_d     = frame_q;
    msg_valid_d = msg_valid;
    msg_d       = msg;
    frame_err_d = frame_err;
    cnt_d       = cnt_q;
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
    unsure_d    = msg_unsure;
`endif
    beat_acc  = in_valid && in_ready;
    last_beat = (beat_q == LAST_BEAT);

    // Saturating per-segment increment for the beat currently addressed
    for (int b = 0; b < int'(NB_BEATS); b++) begin
      for (int i = 0; i < int'(BEAT_W); i++) begin
        cnt_inc[b*BEAT_W+i] = cnt_q[b*BEAT_W+i];
        if ((BI_W'(b) == beat_q) && in_data[i] && (cnt_q[b*BEAT_W+i] != CNT_MAX))
          cnt_inc[b*BEAT_W+i] = cnt_q[b*BEAT_W+i] + CNT_W'(1);
      end
    end

    case (state_q)
      ACCUM: begin
        if (beat_acc) begin
          if (in_last != last_beat) begin
            // Misframed beat: drop it and restart the whole window
            frame_err_d = 1'b1;
            beat_d      = '0;
            frame_d     = '0;
            for (int j = 0; j < int'(NB_SEGMENTS); j++) cnt_d[j] = '0;
          end else begin
            cnt_d = cnt_inc;
            if (last_beat) begin
              beat_d = '0;
              if (frame_q == LAST_FRAME) begin
                frame_d     = '0;
                state_d     = EMIT;
                msg_valid_d = 1'b1;
                for (int j = 0; j < int'(NB_SEGMENTS); j++) begin
                  msg_d[j] = (cnt_inc[j] >= THR);
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
                  unsure_d[j] = (cnt_inc[j] > THR_LO) && (cnt_inc[j] < THR);
`endif
                end
              end else begin
                frame_d = frame_q + FI_W'(1);
              end
            end else begin
              beat_d = beat_q + BI_W'(1);
            end
          end
        end
      end
      EMIT: begin
        if (msg_ready) begin
          msg_valid_d = 1'b0;
          state_d     = ACCUM;
          beat_d      = '0;
          frame_d     = '0;
          for (int j = 0; j < int'(NB_SEGMENTS); j++) cnt_d[j] = '0;
        end
      end
      default: state_d = ACCUM;
    endcase

    in_ready_d = (state_d == ACCUM);
  end

endmodule

// File: tb/tb_display_frame_decoder.sv
// Directed bench for display_frame_decoder: table of decode windows plus framing-error and reset sequences.
// Define DISPLAY_DECODER_CONFIDENCE_EN for both files to exercise msg_unsure.
module tb_display_frame_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        msg_valid;
  logic        msg_ready;
  logic [55:0] msg;
  logic        frame_err;
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
  logic [55:0] msg_unsure;
`endif

  localparam logic [55:0] ONES = {56{1'b1}};

  int nvec  = 0;
  int nmiss = 0;
  int acc   = 0;
  int ev    = 0;
  logic mv_prev = 1'b0;

  display_frame_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .msg_valid (msg_valid),
    .msg_ready (msg_ready),
    .msg       (msg),
    .frame_err (frame_err)
`ifdef DISPLAY_DECODER_CONFIDENCE_EN
    , .msg_unsure (msg_unsure)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts accepted beats and rising edges of msg_valid
  always @(posedge clk) begin
    if (in_valid && in_ready) acc++;
    if (msg_valid && !mv_prev) ev++;
    mv_prev = msg_valid;
  end

  typedef struct {
    logic [55:0] a;
    int          na;
    logic [55:0] b;
    int          nb;
    logic [55:0] c;
    int          hold;
    logic [55:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_last  = 1'b1;
  endtask

  task automatic send_frame(input logic [55:0] m);
    logic [55:0] mm;
    mm = m;
    for (int k = 0; k < 7; k++) send_beat(mm[k*8 +: 8], k == 6);
  endtask

  // Frames f<na use a, f<nb use b, the rest use c; one idle cycle with junk data between frames
  task automatic run_window(input logic [55:0] a, input int na, input logic [55:0] b,
                            input int nb, input logic [55:0] c);
    for (int f = 0; f < 16; f++) begin
      send_frame((f < na) ? a : ((f < nb) ? b : c));
      if (f != 15) begin
        check("mid_window_msg_valid", {63'd0, msg_valid}, 64'd0);
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Hold msg_ready low n cycles while offering beats, then complete the handshake
  task automatic hold_and_take(input int n, input logic [55:0] exp);
    int a0;
    a0 = acc;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check("hold_msg_stable", {8'd0, msg}, {8'd0, exp});
      check("hold_msg_valid", {63'd0, msg_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    msg_ready = 1'b1;
    @(posedge clk);
    #1;
    msg_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_hs_msg_valid", {63'd0, msg_valid}, 64'd0);
    check("post_hs_in_ready", {63'd0, in_ready}, 64'd1);
    check("emit_no_accept", 64'(acc - a0), 64'd0);
  endtask

  task automatic check_emit(input logic [55:0] exp, input int a0);
    check("accept_count", 64'(acc - a0), 64'd112);
    check("msg_valid", {63'd0, msg_valid}, 64'd1);
    check("msg", {8'd0, msg}, {8'd0, exp});
    check("emit_in_ready", {63'd0, in_ready}, 64'd0);
  endtask

  initial begin
    int a0;
    int e0;
    tbl[0] = '{ONES, 16, 56'd0, 16, 56'd0, 0, ONES};
    tbl[1] = '{56'h3, 7, 56'h2, 8, 56'h0, 0, 56'h2};
    tbl[2] = '{56'd0, 16, 56'd0, 16, 56'd0, 0, 56'd0};
    tbl[3] = '{56'hF0F0F0F0F0F0F0, 7, 56'hFF00FF00FF00FF, 8, 56'h0, 0, 56'hF000F000F000F0};
    tbl[4] = '{56'h80000000000001, 16, 56'd0, 16, 56'd0, 20, 56'h80000000000001};
    tbl[5] = '{56'h0, 4, 56'h0, 8, 56'h20, 0, 56'h20};
    tbl[6] = '{56'hAAAAAAAAAAAAAA, 8, 56'h55555555555555, 16, 56'h0, 3, 56'hFFFFFFFFFFFFFF};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    msg_ready = 1'b0;
    #1;
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_msg_valid", {63'd0, msg_valid}, 64'd0);
    check("reset_msg", {8'd0, msg}, 64'd0);
    check("reset_frame_err", {63'd0, frame_err}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    for (int v = 0; v < 7; v++) begin
      a0 = acc;
      run_window(tbl[v].a, tbl[v].na, tbl[v].b, tbl[v].nb, tbl[v].c);
      check_emit(tbl[v].exp, a0);
      check("frame_err_clean", {63'd0, frame_err}, 64'd0);
      hold_and_take(tbl[v].hold, tbl[v].exp);
    end

    // Early in_last on beat 3 of frame 5 aborts the window
    e0 = ev;
    for (int f = 0; f < 5; f++) send_frame(ONES);
    for (int k = 0; k < 3; k++) send_beat(8'hFF, 1'b0);
    send_beat(8'hFF, 1'b1);
    check("frame_err_set", {63'd0, frame_err}, 64'd1);
    check("err_msg_valid", {63'd0, msg_valid}, 64'd0);
    a0 = acc;
    run_window(ONES, 16, 56'd0, 16, 56'd0);
    check_emit(ONES, a0);
    hold_and_take(0, ONES);
    check("single_msg_event", 64'(ev - e0), 64'd1);
    check("frame_err_sticky", {63'd0, frame_err}, 64'd1);

    // Reset during frame 10 loses the partial window
    for (int f = 0; f < 10; f++) send_frame(ONES);
    for (int k = 0; k < 3; k++) send_beat(8'hFF, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_msg_valid", {63'd0, msg_valid}, 64'd0);
    check("midrst_msg", {8'd0, msg}, 64'd0);
    check("midrst_frame_err", {63'd0, frame_err}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_up", {63'd0, in_ready}, 64'd1);
    a0 = acc;
    run_window(56'h00FF00FF00FF00, 16, 56'd0, 16, 56'd0);
    check_emit(56'h00FF00FF00FF00, a0);
    check("midrst_frame_err_clear", {63'd0, frame_err}, 64'd0);
    hold_and_take(0, 56'h00FF00FF00FF00);

`ifdef DISPLAY_DECODER_CONFIDENCE_EN
    // Segment 2 ON in 5 of 16 frames sits in the unsure band
    a0 = acc;
    run_window(56'h4, 5, 56'd0, 16, 56'd0);
    check_emit(56'd0, a0);
    check("unsure", {8'd0, msg_unsure}, 64'h4);
    hold_and_take(0, 56'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
